// File: rtl/bcd_serial_adder_ctrl.sv
// bcd_serial_adder_ctrl
//
// Multi-digit packed-BCD adder controller. One single-digit BCD add stage
// is reused for every digit. Digits are processed least-significant first,
// one digit per clock, and a carry register ripples between them.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   start  - request an operation; only honoured while idle
//   a_bcd  - operand A, packed BCD, digit 0 in [3:0]
//   b_bcd  - operand B, packed BCD
//   cin    - decimal carry into digit 0
//   busy   - high while digits are being added
//   done   - one-cycle pulse; sum/cout/err are valid from this cycle on
//   sum    - packed BCD result
//   cout   - decimal carry out of the top digit
//   err    - at least one operand digit was greater than 9 (sticky per operation)
module bcd_serial_adder_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a_bcd,
  input  logic [4*DIGITS-1:0]   b_bcd,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  // A one-digit build still needs a one-bit index register.
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [4*DIGITS-1:0] a_reg;
  logic [4*DIGITS-1:0] b_reg;
  logic                carry;
  logic [IDXW-1:0]     idx;

  logic [3:0] a_dig;
  logic [3:0] b_dig;
  logic [4:0] s_raw;
  logic [4:0] s_adj;
  logic [3:0] dig_out;
  logic       carry_next;
  logic       dig_bad;

  // Single-digit BCD add stage working on the digit selected by idx.
  // The 5-bit raw sum covers invalid digits too (up to 31); the +6
  // correction is applied whenever the raw sum exceeds 9, with no saturation.
  always_comb begin
    a_dig      = a_reg[{idx, 2'b00} +: 4];
    b_dig      = b_reg[{idx, 2'b00} +: 4];
    s_raw      = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry};
    s_adj      = s_raw + 5'd6;
    dig_out    = s_raw[3:0];
    carry_next = 1'b0;
    if (s_raw > 5'd9) begin
      dig_out    = s_adj[3:0];
      carry_next = 1'b1;
    end
    dig_bad = (a_dig > 4'd9) || (b_dig > 4'd9);
  end

  // Sequencer. Every output is a register, so busy and done are set on
  // the edge that enters the corresponding state rather than decoded.
  // cout is only written on the edge that enters DONE and holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a_bcd;
            b_reg <= b_bcd;
            carry <= cin;
            idx   <= '0;
            err   <= 1'b0;
            sum   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          sum[{idx, 2'b00} +: 4] <= dig_out;
          carry <= carry_next;
          if (dig_bad) begin
            err <= 1'b1;
          end
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= carry_next;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// tb_bcd_serial_adder_ctrl
//
// Directed bench for bcd_serial_adder_ctrl with DIGITS=4. Expected results
// come from a digit-by-digit reference model and are queued when an
// operation is launched, then popped when the DUT raises done.
module tb_bcd_serial_adder_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MAX_WAIT = 40;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_bcd;
  logic [W-1:0] b_bcd;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  int   compared   = 0;
  int   mismatched = 0;
  int   done_count = 0;
  exp_t sb_q[$];

  bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_bcd (a_bcd),
    .b_bcd (b_bcd),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts done pulses, one per clock cycle in which done is high.
  always @(posedge clk) begin
    if (done) done_count <= done_count + 1;
  end

  // Reference: plain digit loop applying the s > 9 correction rule.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c);
    exp_t r;
    int   da, db, s, cy;
    r.sum = '0;
    r.err = 1'b0;
    cy    = int'(c);
    for (int i = 0; i < DIGITS; i++) begin
      da = int'(a[4*i +: 4]);
      db = int'(b[4*i +: 4]);
      s  = da + db + cy;
      if (s > 9) begin
        r.sum[4*i +: 4] = 4'((s + 6) % 16);
        cy = 1;
      end else begin
        r.sum[4*i +: 4] = 4'(s);
        cy = 0;
      end
      if (da > 9 || db > 9) r.err = 1'b1;
    end
    r.cout = cy[0];
    return r;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] got,
                            input logic [31:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Launches one operation: drives operands with start for one edge and
  // queues the expected result. Returns just after the first ADD cycle begins.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic c);
    @(negedge clk);
    a_bcd = a;
    b_bcd = b;
    cin   = c;
    start = 1'b1;
    sb_q.push_back(model(a, b, c));
    @(negedge clk);
    start = 1'b0;
    checkValue("busy_first_add", 32'(busy), 32'd1);
  endtask

  // Waits (bounded) for done, checks latency and the queued result, then
  // checks that done dropped after one cycle. first_cyc is the number of
  // cycles already elapsed since the accept edge.
  task automatic checkOutput(input string tag, input int first_cyc);
    exp_t e;
    int   cyc;
    bit   seen;
    seen = 1'b0;
    cyc  = first_cyc;
    while (!seen && cyc < MAX_WAIT) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_timeout: no done within %0d cycles", tag, MAX_WAIT);
      return;
    end
    checkValue({tag, "_latency"}, 32'(cyc), 32'(DIGITS + 1));
    checkValue({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    if (sb_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_scoreboard: done with empty queue", tag);
    end else begin
      e = sb_q.pop_front();
      checkValue({tag, "_sum"}, 32'(sum), 32'(e.sum));
      checkValue({tag, "_cout"}, 32'(cout), 32'(e.cout));
      checkValue({tag, "_err"}, 32'(err), 32'(e.err));
    end
    @(negedge clk);
    checkValue({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dc;
    rst_n = 1'b0;
    start = 1'b0;
    a_bcd = '0;
    b_bcd = '0;
    cin   = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state, with start held high: reset must win.
    start = 1'b1;
    a_bcd = 16'h1111;
    @(negedge clk);
    checkValue("rst_busy", 32'(busy), 32'd0);
    checkValue("rst_done", 32'(done), 32'd0);
    checkValue("rst_sum",  32'(sum),  32'd0);
    checkValue("rst_cout", 32'(cout), 32'd0);
    checkValue("rst_err",  32'(err),  32'd0);
    start = 1'b0;
    rst_n = 1'b1;

    // Basic additions and carry boundaries.
    applyStimulus(16'h1234, 16'h5678, 1'b0);
    checkOutput("add_basic", 1);
    applyStimulus(16'h9999, 16'h0001, 1'b0);
    checkOutput("carry_out", 1);
    applyStimulus(16'h0999, 16'h0001, 1'b0);
    checkOutput("carry_ripple", 1);
    applyStimulus(16'h0000, 16'h0000, 1'b1);
    checkOutput("cin_only", 1);
    applyStimulus(16'h9999, 16'h9999, 1'b1);
    checkOutput("max_cin", 1);

    // Invalid digit: err set, result still follows the correction rule.
    applyStimulus(16'h00A0, 16'h0000, 1'b0);
    checkOutput("bad_digit", 1);
    // Holds outputs in idle after the operation.
    repeat (2) @(negedge clk);
    checkValue("idle_hold_sum", 32'(sum), 32'h0100);
    checkValue("idle_hold_err", 32'(err), 32'd1);
    applyStimulus(16'h0042, 16'h0057, 1'b0);
    checkOutput("err_clear", 1);

    // start pulsed in ADD with new operands must be ignored.
    dc = done_count;
    applyStimulus(16'h1234, 16'h5678, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a_bcd = 16'h9999;
    b_bcd = 16'h9999;
    cin   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_in_add", 3);
    repeat (DIGITS + 3) @(negedge clk);
    checkValue("single_done", 32'(done_count - dc), 32'd1);
    checkValue("no_requeue_busy", 32'(busy), 32'd0);
    checkValue("no_requeue_sum", 32'(sum), 32'h6912);

    // Reset on the second ADD cycle aborts with no done.
    dc = done_count;
    applyStimulus(16'h4321, 16'h1111, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkValue("abort_busy", 32'(busy), 32'd0);
    checkValue("abort_done", 32'(done), 32'd0);
    checkValue("abort_sum",  32'(sum),  32'd0);
    checkValue("abort_cout", 32'(cout), 32'd0);
    checkValue("abort_err",  32'(err),  32'd0);
    rst_n = 1'b1;
    void'(sb_q.pop_back());
    repeat (DIGITS + 3) @(negedge clk);
    checkValue("abort_no_done", 32'(done_count - dc), 32'd0);
    applyStimulus(16'h2580, 16'h7419, 1'b1);
    checkOutput("after_abort", 1);

    checkValue("queue_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
